// File: rtl/mux_mode_scheduler_pkg.sv
// Shared video mode definitions for the pixel mux select path.
// Mode enums, the staged/applied pair type and its 4-bit auto-advance step.
package video_modes_pkg;

  typedef enum logic [1:0] {
    BG_CAMERA  = 2'd0,
    BG_CHANNEL = 2'd1,
    BG_THRESH  = 2'd2,
    BG_YMASK   = 2'd3
  } bg_mode_t;

  typedef enum logic [1:0] {
    TGT_NONE      = 2'd0,
    TGT_CROSSHAIR = 2'd1,
    TGT_SPRITE    = 2'd2,
    TGT_MARK      = 2'd3
  } tgt_mode_t;

  typedef enum logic {
    SCHED_IDLE   = 1'b0,
    SCHED_STAGED = 1'b1
  } sched_state_t;

  typedef struct packed {
    tgt_mode_t target;
    bg_mode_t  bg;
  } mode_pair_t;

  localparam bg_mode_t   DEFAULT_BG   = BG_CAMERA;
  localparam tgt_mode_t  DEFAULT_TGT  = TGT_NONE;
  localparam mode_pair_t DEFAULT_MODE = '{target: DEFAULT_TGT, bg: DEFAULT_BG};

  // Treat {target,bg} as one 4-bit counter: bg wrapping past YMASK carries into target.
  function automatic mode_pair_t mode_step(input mode_pair_t m);
    mode_pair_t r;
    r = m;
    r.bg = bg_mode_t'(m.bg + 2'd1);
    if (m.bg == BG_YMASK) begin
      r.target = tgt_mode_t'(m.target + 2'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_mode_scheduler_if.sv
// Button/frame inputs and mux select outputs of the mode scheduler.
interface mux_mode_scheduler_if;
  logic       btn_bg_in;
  logic       btn_target_in;
  logic       auto_en_in;
  logic       new_frame_in;
  logic [1:0] bg_out;
  logic [1:0] target_out;
  logic       pending_out;
  logic       mode_changed_out;

  modport master (
    output btn_bg_in, btn_target_in, auto_en_in, new_frame_in,
    input  bg_out, target_out, pending_out, mode_changed_out
  );

  modport slave (
    input  btn_bg_in, btn_target_in, auto_en_in, new_frame_in,
    output bg_out, target_out, pending_out, mode_changed_out
  );
endinterface

// File: rtl/mux_mode_scheduler_debouncer.sv
// Two-flop synchronizer plus stability-counter debouncer for one raw button.
// press_out pulses for one cycle when the debounced level rises.
module button_debouncer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
  output logic press_out
);

  logic        sync_meta;
  logic        sync_btn;
  logic        level;
  logic [15:0] stable_cnt;
  logic        flip;

  // The counter only runs while the synchronized input disagrees with the level.
  assign flip = (sync_btn != level) && (stable_cnt == DEBOUNCE_CYCLES - 16'd1);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_meta  <= 1'b0;
      sync_btn   <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= 16'd0;
      press_out  <= 1'b0;
    end else begin
      sync_meta <= btn_in;
      sync_btn  <= sync_meta;
      press_out <= flip && sync_btn;
      if (sync_btn == level) begin
        stable_cnt <= 16'd0;
      end else if (flip) begin
        level      <= sync_btn;
        stable_cnt <= 16'd0;
      end else begin
        stable_cnt <= stable_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/mux_mode_scheduler.sv
// Frame-synchronous bg/overlay mode select controller: debounced button requests
// and optional auto-cycling are staged and only applied on a new_frame_in pulse.
module mux_mode_scheduler
  import video_modes_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  AUTO_FRAMES     = 8'd120
) (
  input logic             clk_in,
  input logic             rst_in,
  mux_mode_scheduler_if.slave bus
);

  logic         req_bg;
  logic         req_target;
  logic         auto_step;
  logic         changed_d;
  logic         changed_q;
  logic [7:0]   frame_cnt_d;
  logic [7:0]   frame_cnt_q;
  mode_pair_t   staged_d;
  mode_pair_t   staged_q;
  mode_pair_t   applied_d;
  mode_pair_t   applied_q;
  sched_state_t state_d;
  sched_state_t state_q;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bg_debounce (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .btn_in    (bus.btn_bg_in),
    .press_out (req_bg)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_target_debounce (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .btn_in    (bus.btn_target_in),
    .press_out (req_target)
  );

  // Next staged value folds in same-cycle requests and the auto step before any apply.
  always_comb begin
    staged_d    = staged_q;
    applied_d   = applied_q;
    frame_cnt_d = frame_cnt_q;
    changed_d   = 1'b0;
    state_d     = state_q;
    auto_step   = bus.auto_en_in && bus.new_frame_in &&
                  (frame_cnt_q == AUTO_FRAMES - 8'd1);

    if (req_bg) begin
      staged_d.bg = bg_mode_t'(staged_q.bg + 2'd1);
    end
    if (req_target) begin
      staged_d.target = tgt_mode_t'(staged_q.target + 2'd1);
    end
    if (auto_step) begin
      staged_d = mode_step(staged_d);
    end

    if (req_bg || req_target || !bus.auto_en_in) begin
      frame_cnt_d = 8'd0;
    end else if (bus.new_frame_in) begin
      frame_cnt_d = auto_step ? 8'd0 : frame_cnt_q + 8'd1;
    end

    if (bus.new_frame_in) begin
      applied_d = staged_d;
      changed_d = (staged_d != applied_q);
    end

    // STAGED also collapses back to IDLE when wrapping lands on the applied value.
    case (state_q)
      SCHED_IDLE: begin
        if (staged_d != applied_d) begin
          state_d = SCHED_STAGED;
        end
      end
      SCHED_STAGED: begin
        if (bus.new_frame_in || (staged_d == applied_d)) begin
          state_d = SCHED_IDLE;
        end
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      staged_q    <= DEFAULT_MODE;
      applied_q   <= DEFAULT_MODE;
      frame_cnt_q <= 8'd0;
      changed_q   <= 1'b0;
      state_q     <= SCHED_IDLE;
    end else begin
      staged_q    <= staged_d;
      applied_q   <= applied_d;
      frame_cnt_q <= frame_cnt_d;
      changed_q   <= changed_d;
      state_q     <= state_d;
    end
  end

  assign bus.bg_out           = applied_q.bg;
  assign bus.target_out       = applied_q.target;
  assign bus.pending_out      = (state_q == SCHED_STAGED);
  assign bus.mode_changed_out = changed_q;

endmodule
